// File: rtl/boot_loader_if.sv
// Handshake and bus bundle between the boot loader and its surroundings.
// The slave side is the loader; the master side drives the byte stream and the core's done flag.
interface boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        core_done;
    logic        boot_done;
    logic        err;
    logic [31:0] cycle_count;

    modport master (
        output in_valid, in_data, core_done,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, boot_done, err, cycle_count
    );

    modport slave (
        input  in_valid, in_data, core_done,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst, boot_done, err, cycle_count
    );
endinterface

// File: rtl/boot_loader.sv
// Loads a length-prefixed little-endian byte image into core memory, releases the core,
// then times its run until done or until the cycle limit trips.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    boot_loader_if.slave  bus_if
);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, RUN, DONE, ERR} state_e;

    state_e      state_q, state_d;
    logic [7:0]  lenLo_q, lenLo_d;
    logic [15:0] wordCount_q, wordCount_d;
    logic [15:0] wordIdx_q, wordIdx_d;
    logic [1:0]  byteCnt_q, byteCnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic [31:0] cycleCount_q, cycleCount_d;
    logic        inReady_q, memWe_q, coreRst_q, bootDone_q, err_q;
    logic [15:0] lenFull;
    logic        xfer;

    // in_ready is registered from the state, so it doubles as the accept qualifier
    assign xfer    = bus_if.in_valid & inReady_q;
    assign lenFull = {bus_if.in_data, lenLo_q};

    always_comb begin
        state_d      = state_q;
        lenLo_d      = lenLo_q;
        wordCount_d  = wordCount_q;
        wordIdx_d    = wordIdx_q;
        byteCnt_d    = byteCnt_q;
        word_d       = word_q;
        memAddr_d    = memAddr_q;
        memWdata_d   = memWdata_q;
        cycleCount_d = cycleCount_q;
        case (state_q)
            LEN0: begin
                if (xfer) begin
                    lenLo_d = bus_if.in_data;
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    if (lenFull == 16'd0 || 32'(lenFull) > 32'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        wordCount_d = lenFull;
                        wordIdx_d   = 16'd0;
                        byteCnt_d   = 2'd0;
                        state_d     = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    word_d[{byteCnt_q, 3'b000} +: 8] = bus_if.in_data;
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        memAddr_d  = BASE_ADDR + {14'd0, wordIdx_q, 2'b00};
                        memWdata_d = word_d;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                wordIdx_d = wordIdx_q + 16'd1;
                state_d   = (wordIdx_q == wordCount_q - 16'd1) ? RUN : DATA;
            end
            RUN: begin
                if (bus_if.core_done) begin
                    state_d = DONE;
                end else if (cycleCount_q == 32'(MAX_CYCLES)) begin
                    state_d = ERR;
                end else begin
                    cycleCount_d = cycleCount_q + 32'd1;
                end
            end
            DONE, ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = LEN0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= LEN0;
            lenLo_q      <= 8'd0;
            wordCount_q  <= 16'd0;
            wordIdx_q    <= 16'd0;
            byteCnt_q    <= 2'd0;
            word_q       <= 32'd0;
            memAddr_q    <= BASE_ADDR;
            memWdata_q   <= 32'd0;
            cycleCount_q <= 32'd0;
            inReady_q    <= 1'b0;
            memWe_q      <= 1'b0;
            coreRst_q    <= 1'b1;
            bootDone_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lenLo_q      <= lenLo_d;
            wordCount_q  <= wordCount_d;
            wordIdx_q    <= wordIdx_d;
            byteCnt_q    <= byteCnt_d;
            word_q       <= word_d;
            memAddr_q    <= memAddr_d;
            memWdata_q   <= memWdata_d;
            cycleCount_q <= cycleCount_d;
            inReady_q    <= (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
            memWe_q      <= (state_d == WRITE);
            coreRst_q    <= (state_d != RUN);
            bootDone_q   <= (state_d == DONE);
            err_q        <= (state_d == ERR);
        end
    end

    assign bus_if.in_ready    = inReady_q;
    assign bus_if.mem_we      = memWe_q;
    assign bus_if.mem_addr    = memAddr_q;
    assign bus_if.mem_wdata   = memWdata_q;
    assign bus_if.core_rst    = coreRst_q;
    assign bus_if.boot_done   = bootDone_q;
    assign bus_if.err         = err_q;
    assign bus_if.cycle_count = cycleCount_q;

endmodule

// File: doc/boot_loader.md
# boot_loader

Upstream companion to the multicycle RISC-V core. Receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes the words into the core's unified instruction/data memory, then releases the core from reset. Measures run length until the core raises `done`, flags malformed images and runaway programs, and freezes the core afterwards.

## Interface
- `BASE_ADDR`, default 0: byte address of the first program word.
- `MAX_WORDS`, default 1024: largest accepted image, in words.
- `MAX_CYCLES`, default 100000: run-time limit, in core clock cycles.
- `clk`, input, 1: clock, shared with the core.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `in_valid`, input, 1: byte stream valid.
- `in_data`, input, 8: byte stream data.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `mem_we`, output, 1: memory write strobe (one cycle per word).
- `mem_addr`, output, 32: memory byte address.
- `mem_wdata`, output, 32: memory write data.
- `core_rst`, output, 1: active-high reset to the core.
- `core_done`, input, 1: core `done` flag.
- `boot_done`, output, 1: program finished normally.
- `err`, output, 1: bad length or timeout.
- `cycle_count`, output, 32: core run cycles.

## Operation
- **Stream format.** Two bytes give the word count N as a 16-bit little-endian value. These are followed by 4N bytes, each group of four forming one little-endian word (first byte = bits [7:0]).
- **Byte transfer.** A byte transfers on a rising edge with `in_valid & in_ready`.
- **FSM states:** LEN0, LEN1, DATA, WRITE, RUN, DONE, ERR.
- **LEN0.** `in_ready=1`. On a transfer, store the low length byte and go to LEN1.
- **LEN1.** `in_ready=1`. On a transfer, form N.
  - N==0 or N>MAX_WORDS: go to ERR.
  - Otherwise: clear the byte counter and word index, and go to DATA.
- **DATA.** `in_ready=1`. Each transfer shifts the byte into the word assembly register at lane byte_cnt (2-bit). When the 4th byte transfers, go to WRITE.
- **WRITE.** `in_ready=0`, `mem_we=1` for exactly one cycle.
  - `mem_addr` = BASE_ADDR + 4*idx (32-bit, wraps modulo 2^32).
  - `mem_wdata` = the assembled word.
  - Then idx increments. If idx was N-1, go to RUN; otherwise go back to DATA.
- **RUN.** `core_rst=0`, `in_ready=0`.
  - Each edge with `core_done=0` increments `cycle_count`.
  - An edge with `core_done=1` goes to DONE without incrementing.
  - If `cycle_count` equals MAX_CYCLES while `core_done=0`, go to ERR instead.
- **DONE.** `boot_done=1`, `core_rst=1` (core frozen), `cycle_count` held. Terminal state.
- **ERR.** `err=1`, `core_rst=1`, `in_ready=0`, `cycle_count` held. Terminal state; only `rst` leaves it.
- **`core_done` outside RUN** is ignored.
- **Output drive.** `mem_addr` and `mem_wdata` hold their last values outside WRITE. `mem_we` is 0 outside WRITE.

## Timing
- **Reset values** (`rst=0`, asynchronous):
  - state LEN0, `in_ready=0` while `rst` is asserted, then 1 once in LEN0
  - `mem_we=0`, `mem_addr=BASE_ADDR`, `mem_wdata=0`
  - `core_rst=1`, `boot_done=0`, `err=0`, `cycle_count=0`
  - byte counter and word index 0
- **Output type.** All outputs are registered or decoded from state only (Moore). No combinational path from `in_valid`/`in_data`/`core_done` to any output.
- **Load throughput.** Peak is 5 cycles per word: 4 byte transfers plus 1 WRITE cycle. `in_valid` gaps stall DATA with no loss of the partial word.
- **Write latency.** `mem_we` is high in the cycle immediately after the edge accepting the 4th byte of a word.
- **Core release.** `core_rst` falls on the edge ending the last WRITE cycle. The core's first active cycle is the next cycle.
- **`cycle_count`** equals the number of RUN cycles before the one in which `core_done` was sampled high.
- **`boot_done` / `err`** rise on the edge after the terminating condition and stay high until `rst`.
- **Mid-operation reset.** `rst` asserted mid-load or mid-run aborts immediately. `core_rst` returns to 1 asynchronously. A partially written memory is not cleaned.

## Test plan
- **Normal run.** N=2, bytes 02 00 13 00 50 00 93 00 A0 00, core_done raised 7 cycles after release → writes 0x00500013@0 and 0x00A00093@4, core_rst falls after 2nd WRITE, boot_done=1, cycle_count=7.
- **Back-pressure.** Same image with in_valid low for 3 cycles between bytes 2 and 3 of word 0 → identical memory writes, no duplicated or lost bytes, in_ready never drops in DATA.
- **Zero length.** Bytes 00 00 → err=1 one edge after 2nd byte, no mem_we, core_rst stays 1.
- **Oversize image.** MAX_WORDS=4, length 05 00 → err=1, no writes.
- **Timeout.** MAX_CYCLES=10, core_done held 0 → err=1 when cycle_count reaches 10, core_rst re-asserted, boot_done=0.
- **Reset mid-run.** rst pulsed low mid-RUN → all outputs return to reset values immediately. The following stream with N=1 loads and runs normally.
